// File: rtl/round_start_ctrl.sv
// Round-start sequencer for the Tug-of-War game.
// Gathers a seed from the serial LFSR stream, waits MIN_WAIT + seed ticks,
// then opens the round with go. A button press while busy is a false start.
// The random input is named rand_in because rand is a reserved word in
// SystemVerilog.
module round_start_ctrl #(
    parameter int SEED_BITS = 6,
    parameter int MIN_WAIT  = 32,
    parameter int TICK_DIV  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               rand_in,
    input  logic               btn_a,
    input  logic               btn_b,
    output logic               go,
    output logic               foul_a,
    output logic               foul_b,
    output logic               busy,
    output logic [SEED_BITS:0] wait_val
);

    localparam int CW = $clog2(SEED_BITS + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = SEED_BITS + 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(SEED_BITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] MIN_W    = WW'(MIN_WAIT);
    localparam logic [WW-1:0] ONE_TICK = WW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER,
        ST_WAIT,
        ST_GO,
        ST_FOUL
    } state_t;

    state_t               state_q, state_d;
    logic [SEED_BITS-1:0] seed_q, seed_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [WW-1:0]        wait_val_q, wait_val_d;
    logic                 foul_a_q, foul_a_d;
    logic                 foul_b_q, foul_b_d;
    logic [SEED_BITS-1:0] final_seed;

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            seed_q     <= '0;
            bit_cnt_q  <= '0;
            pre_q      <= '0;
            wait_cnt_q <= '0;
            wait_val_q <= '0;
            foul_a_q   <= 1'b0;
            foul_b_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            seed_q     <= seed_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_q      <= pre_d;
            wait_cnt_q <= wait_cnt_d;
            wait_val_q <= wait_val_d;
            foul_a_q   <= foul_a_d;
            foul_b_q   <= foul_b_d;
        end
    end

    // Next-state and datapath update: start wins, then the state's own work,
    // then a false start overrides whatever the state would have done.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of latches.
        state_d    = state_q;
        seed_d     = seed_q;
        bit_cnt_d  = bit_cnt_q;
        pre_d      = pre_q;
        wait_cnt_d = wait_cnt_q;
        wait_val_d = wait_val_q;
        foul_a_d   = foul_a_q;
        foul_b_d   = foul_b_q;
        final_seed = {seed_q[SEED_BITS-2:0], rand_in};

        if (start) begin
            state_d   = ST_GATHER;
            seed_d    = '0;
            bit_cnt_d = '0;
            foul_a_d  = 1'b0;
            foul_b_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GO, ST_FOUL: ;
                ST_GATHER: begin
                    seed_d    = final_seed;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = MIN_W + {1'b0, final_seed};
                        wait_val_d = MIN_W + {1'b0, final_seed};
                        pre_d      = '0;
                    end
                end
                ST_WAIT: begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (wait_cnt_q == ONE_TICK) begin
                            state_d = ST_GO;
                        end else begin
                            wait_cnt_d = wait_cnt_q - ONE_TICK;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if ((state_q == ST_GATHER || state_q == ST_WAIT) && (btn_a || btn_b)) begin
                state_d  = ST_FOUL;
                foul_a_d = btn_a;
                foul_b_d = btn_b;
            end
        end
    end

    assign go       = (state_q == ST_GO);
    assign busy     = (state_q == ST_GATHER) || (state_q == ST_WAIT);
    assign foul_a   = foul_a_q;
    assign foul_b   = foul_b_q;
    assign wait_val = wait_val_q;

endmodule

// File: tb/tb_round_start_ctrl.sv
// Scoreboard bench for round_start_ctrl (SEED_BITS=3, MIN_WAIT=4, TICK_DIV=4).
// Stimulus pushes each expected output change (edge number + output vector);
// the monitor pops one entry whenever the observed outputs change.
module tb_round_start_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rand_in;
    logic       btn_a;
    logic       btn_b;
    logic       go;
    logic       foul_a;
    logic       foul_b;
    logic       busy;
    logic [3:0] wait_val;

    round_start_ctrl #(
        .SEED_BITS(3),
        .MIN_WAIT (4),
        .TICK_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rand_in (rand_in),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .go      (go),
        .foul_a  (foul_a),
        .foul_b  (foul_b),
        .busy    (busy),
        .wait_val(wait_val)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n has been taken, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_vec = 8'h00;
    int         e0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Observed vector: {busy, go, foul_a, foul_b, wait_val}.
    function automatic logic [7:0] obs();
        return {busy, go, foul_a, foul_b, wait_val};
    endfunction

    task automatic check(input string name, input int got_cyc, input logic [7:0] got_vec,
                         input int want_cyc, input logic [7:0] want_vec);
        n_cmp++;
        if (got_cyc != want_cyc || got_vec !== want_vec) begin
            n_bad++;
            $display("FAIL %s: got edge %0d outputs %b, expected edge %0d outputs %b",
                     name, got_cyc, got_vec, want_cyc, want_vec);
        end
    endtask

    // Record an expected output change; repeats of the current value are not changes.
    task automatic exp_abs(input int c, input logic [7:0] v, input string name);
        if (v !== exp_vec) begin
            exp_q.push_back('{c, v, name});
            exp_vec = v;
        end
    endtask

    task automatic exp_at(input int off, input logic b, input logic g, input logic fa,
                          input logic fb, input logic [3:0] wv, input string name);
        exp_abs(e0 + off, {b, g, fa, fb, wv}, name);
    endtask

    // Called at a negedge: start is sampled at the next edge (E0).
    task automatic arm(input string name);
        start = 1'b1;
        e0    = cyc + 1;
        exp_at(0, 1'b1, 1'b0, 1'b0, 1'b0, exp_vec[3:0], name);
    endtask

    // Drops start and presents the seed bits for E1..E3, MSB first.
    task automatic feed(input logic [2:0] bits);
        @(negedge clk); start = 1'b0; rand_in = bits[2];
        @(negedge clk); rand_in = bits[1];
        @(negedge clk); rand_in = bits[0];
        @(negedge clk);
    endtask

    // Returns at the negedge just before edge E<off> of the current round.
    task automatic before_edge(input int off);
        while (cyc < e0 + off - 1) @(negedge clk);
    endtask

    // Monitor: compare every output change against the head of the scoreboard.
    initial begin
        logic [7:0] prev;
        logic [7:0] cur;
        exp_t       e;
        prev = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cur = obs();
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected change: got edge %0d outputs %b, expected no change (was %b)",
                             cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, cyc, cur, e.cyc, e.vec);
                end
                prev = cur;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, expected finish within 200000 time units");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; rand_in = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT clears all outputs asynchronously; buttons alone do nothing after.
        arm("r1 start");
        exp_at(3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, "r1 load");
        feed(3'b101);
        before_edge(20);
        rst = 1'b0;
        #1;
        check("reset immediate", 0, obs(), 0, 8'h00);
        exp_abs(cyc + 1, 8'h00, "reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        btn_a = 1'b1; btn_b = 1'b1;
        repeat (4) @(negedge clk);
        btn_a = 1'b0; btn_b = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal round: seed 101 -> wait 9 ticks, go at E39, held 100 cycles.
        arm("nom start");
        exp_at(3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd9, "nom load");
        exp_at(39, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, "nom go");
        feed(3'b101);
        before_edge(140);

        // Restart from GO, seed 000 -> wait 4, go at E19.
        arm("s0 start");
        exp_at(3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd4, "s0 load");
        exp_at(19, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, "s0 go");
        feed(3'b000);
        before_edge(25);

        // Restart from GO, seed 111 -> wait 11, go at E47.
        arm("s7 start");
        exp_at(3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd11, "s7 load");
        exp_at(47, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11, "s7 go");
        feed(3'b111);
        before_edge(52);

        // False start by B at E20 of a nominal round.
        arm("fb start");
        exp_at(3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd9, "fb load");
        exp_at(20, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, "foul b");
        feed(3'b101);
        before_edge(20);
        btn_b = 1'b1;
        @(negedge clk);
        btn_b = 1'b0;
        before_edge(60);

        // Restart from FOUL; both buttons on the GO edge E39: foul wins.
        arm("fab start");
        exp_at(39, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, "foul both at go edge");
        feed(3'b101);
        before_edge(39);
        btn_a = 1'b1; btn_b = 1'b1;
        @(negedge clk);
        btn_a = 1'b0; btn_b = 1'b0;
        before_edge(50);

        // Restart from FOUL; A presses during GATHER at E2.
        arm("ga start");
        exp_at(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, "gather foul a");
        @(negedge clk); start = 1'b0; rand_in = 1'b1;
        @(negedge clk); btn_a = 1'b1; rand_in = 1'b0;
        @(negedge clk); btn_a = 1'b0;
        before_edge(20);

        // Restart mid-WAIT: timing follows the new E0.
        arm("rw start");
        exp_at(3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, "rw load");
        feed(3'b000);
        before_edge(10);
        arm("rw restart");
        exp_at(3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd11, "rw reload");
        exp_at(47, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11, "rw go");
        feed(3'b111);
        before_edge(55);

        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d expected changes never seen (next '%s' at edge %0d), expected 0",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_start_ctrl.md
# round_start_ctrl

Round-start sequencer for the Tug-of-War game. It consumes the serial pseudo-random bit stream from the free-running 10-bit LFSR and collects `SEED_BITS` bits into a seed. It then waits a random interval of `MIN_WAIT + seed` ticks and raises `go` to open the round. A button press during the gather or wait interval is a false start: the round aborts and the offending player(s) are flagged.

## Interface
Parameters:
- `SEED_BITS`, default 6: number of LFSR bits collected per round; range 2..8.
- `MIN_WAIT`, default 32: minimum wait in ticks; range 1..2^SEED_BITS.
- `TICK_DIV`, default 1000: clk cycles per tick; must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse; begins (or restarts) a round.
- `rand`  input  1  serial random bit from the LFSR; sampled every clk while gathering.
- `btn_a`  input  1  player A button, already synchronized and debounced; level.
- `btn_b`  input  1  player B button, already synchronized and debounced; level.
- `go`  output  1  round open; level.
- `foul_a`  output  1  player A false start; latched level.
- `foul_b`  output  1  player B false start; latched level.
- `busy`  output  1  high in the GATHER and WAIT states.
- `wait_val`  output  SEED_BITS+1  tick count loaded for the current round.

## Operation
- States: IDLE, GATHER, WAIT, GO, FOUL. Reset state is IDLE.
- Reset values: all outputs 0; seed register, bit counter, prescaler and `wait_cnt` cleared.
- `start` is checked in every state and has the highest priority. When high, the next state is GATHER and the following are cleared: bit counter, seed, `go`, `foul_a`, `foul_b`. This lets a round restart mid-operation.
- GATHER:
  - Each cycle, `seed <= {seed[SEED_BITS-2:0], rand}`. The first sampled bit becomes the MSB.
  - After the SEED_BITS-th sample, go to WAIT.
  - In that same edge, load `wait_cnt` and `wait_val` with `MIN_WAIT + final_seed`, and clear the prescaler.
- WAIT:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - On each wrap, if `wait_cnt == 1`, go to GO; otherwise decrement `wait_cnt`.
- False start:
  - `btn_a` or `btn_b` high in GATHER or WAIT, with `start` low, moves the state to FOUL.
  - `foul_a` is set to `btn_a` and `foul_b` is set to `btn_b`. If both buttons are pressed in the same cycle, both flags are set.
  - A false start overrides a GO transition on the same edge.
- GO: `go = 1`; held until `start`.
- FOUL: the foul flags are held until `start`.
- Buttons are ignored in IDLE, GO and FOUL.
- Arithmetic:
  - `wait_cnt` is SEED_BITS+1 bits wide.
  - The largest value is 2^S + 2^S − 1, so the counter never overflows and never reaches 0 in WAIT.
- `wait_val` keeps its value through GO and FOUL. It is cleared only by reset and reloaded at the end of the next GATHER.

## Timing
- Let E0 be the clock edge at which `start` is sampled high.
- Seed bits are sampled at edges E1..E_S; `busy` is high from E0.
- WAIT lasts exactly (MIN_WAIT + seed) × TICK_DIV cycles. `go` rises at edge E_S + (MIN_WAIT + seed) × TICK_DIV, and `busy` falls on the same edge.
- Foul latency: a button first seen high at edge En sets `foul_x` after En; `busy` falls on the same edge.
- Reset deassertion with `start` already high: the first synchronous edge acts as E0.
- Reset asserted mid-round: all outputs clear immediately (asynchronous).

## Test plan
Bench parameters: SEED_BITS=3, MIN_WAIT=4, TICK_DIV=4; `rand` is driven directly by the bench.
- Reset: hold `rst` low mid-WAIT → `go`, `busy`, both foul flags and `wait_val` read 0 immediately. After release the state is IDLE, and buttons alone cause no change.
- Nominal round: `start` at E0, `rand` = 1,0,1 at E1..E3 → `wait_val` = 9, `busy` high E0..E39, `go` rises at E39 and stays high for 100 more cycles.
- Seed boundaries:
  - `rand` = 0,0,0 → `wait_val` = 4, `go` at E19.
  - `rand` = 1,1,1 → `wait_val` = 11, `go` at E47.
- False start: `btn_b` high at E20 of the nominal round → `foul_b` = 1 and `foul_a` = 0 after E20. `go` never rises; `busy` falls at E20.
- Simultaneous foul and GO edge: both buttons high at E39 → `foul_a` = `foul_b` = 1 and `go` = 0. A button pressed during GATHER (E2) also fouls.
- Restart: `start` pulse in WAIT, GO and FOUL → flags and `go` clear, a new gather begins, and `go` timing matches the nominal case relative to the new E0.
